// File: rtl/poly_byte_encode12.sv
// -----------------------------------------------------------------------------
// poly_byte_encode12
//
// Packs one ML-KEM polynomial (256 coefficients, 12 bits each) into the
// ByteEncode12 byte stream (384 bytes = 3072 bits) and emits it as WORD_W-bit
// beats on a valid/ready stream. Stream bit 12k+b is bit b of coefficient k.
// Beat w carries stream bits [WORD_W*w +: WORD_W], so bytes come out
// little-endian within each beat.
//
// Parameters
//   WORD_W   output beat width; must divide 3072 exactly (32/64/96/128/192/384)
//
// Ports
//   clk_i    in   1            clock
//   rst_i    in   1            asynchronous, active-high reset
//   run_i    in   1            start pulse; poly_i is sampled when idle
//   poly_i   in   [255:0][11:0] poly_i[k] = coefficient k (same layout as poly_t)
//   data_o   out  WORD_W       current beat
//   valid_o  out  1            data_o holds a valid beat
//   ready_i  in   1            sink accepts the beat when valid_o && ready_i
//   last_o   out  1            high with valid_o on the final beat
//   busy_o   out  1            high while beats are being sent
//   done_o   out  1            one-cycle pulse after the final beat is accepted
//
// Build option
//   ENCODE_MODQ_EN  when defined, each coefficient is conditionally reduced
//                   (c >= 3329 ? c - 3329 : c) as it is loaded. When undefined,
//                   coefficients are packed raw and the caller guarantees c < q.
// -----------------------------------------------------------------------------
module poly_byte_encode12 #(
    parameter int WORD_W = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                run_i,
    input  logic [255:0][11:0]  poly_i,
    output logic [WORD_W-1:0]   data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                last_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int POLY_W  = 3072;
    localparam int N_BEATS = POLY_W / WORD_W;
    // A single-beat configuration still needs a 1-bit counter to be legal.
    localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BEATS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [POLY_W-1:0] pack_q,  pack_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic [POLY_W-1:0] packed_poly;
    logic [11:0]       coef_v;

    // Coefficient k lands at stream bits [12k +: 12]; the optional reduction
    // is a single conditional subtract since inputs never exceed 4095 < 2q.
    always_comb begin
        packed_poly = '0;
        coef_v      = '0;
        for (int k = 0; k < 256; k++) begin
`ifdef ENCODE_MODQ_EN
            coef_v = (poly_i[k] >= 12'd3329) ? (poly_i[k] - 12'd3329) : poly_i[k];
`else
            coef_v = poly_i[k];
`endif
            packed_poly[12*k +: 12] = coef_v;
        end
    end

    // Next-state logic. The pack register always presents the current beat in
    // its low WORD_W bits, so each accept is a plain right shift.
    always_comb begin
        state_d = state_q;
        pack_d  = pack_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (run_i) begin
                    state_d = ST_SEND;
                    pack_d  = packed_poly;
                    cnt_d   = '0;
                end
            end
            ST_SEND: begin
                if (ready_i) begin
                    pack_d = pack_q >> WORD_W;
                    // The counter parks on the last index rather than wrapping.
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                // run_i is deliberately not looked at here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pack_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pack_q  <= pack_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs decode directly from registered state, so a reset drops
    // valid_o/busy_o immediately and no done_o is produced for a partial stream.
    assign valid_o = (state_q == ST_SEND);
    assign busy_o  = (state_q == ST_SEND);
    assign done_o  = (state_q == ST_DONE);
    assign last_o  = valid_o && (cnt_q == LAST_CNT);
    assign data_o  = pack_q[WORD_W-1:0];

endmodule

// File: tb/tb_poly_byte_encode12.sv
module tb_poly_byte_encode12;

    localparam int WORD_W  = 64;
    localparam int N_BEATS = 3072 / WORD_W;

`ifdef ENCODE_MODQ_EN
    localparam logic [63:0] FFF_B0  = 64'hE2FE2FE2FE2FE2FE;
    localparam logic [63:0] FFF_B47 = 64'h2FE2FE2FE2FE2FE2;
    localparam logic [63:0] T6_B0   = 64'h00000000000002FE;
`else
    localparam logic [63:0] FFF_B0  = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] FFF_B47 = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] T6_B0   = 64'h0000000000D01FFF;
`endif

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                run_i;
    logic [255:0][11:0]  poly_i;
    logic [WORD_W-1:0]   data_o;
    logic                valid_o;
    logic                ready_i;
    logic                last_o;
    logic                busy_o;
    logic                done_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] coef [256];
    logic [63:0] got_b0;
    logic [63:0] got_b47;

    always #5 clk_i = ~clk_i;

    poly_byte_encode12 #(.WORD_W(WORD_W)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .run_i   (run_i),
        .poly_i  (poly_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .last_o  (last_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    typedef struct {
        int          kind;     // 0 zero, 1 ramp, 2 all 4095, 3 T6 pair, 4 random
        int          rmode;    // 0 ready high, 1 toggling, 2 random
        bit          chk;      // compare beat 0 / beat 47 against constants
        logic [63:0] b0;
        logic [63:0] b47;
        int          exp_cyc;  // cycles first valid .. last accept, <=0 skip
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] modq(input logic [11:0] c);
`ifdef ENCODE_MODQ_EN
        return (c >= 12'd3329) ? (c - 12'd3329) : c;
`else
        return c;
`endif
    endfunction

    // Reference: beat w bit i is stream bit s = 64w+i, which is bit s%12 of
    // coefficient s/12.
    function automatic logic [63:0] ref_beat(input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            int          s;
            logic [11:0] v;
            s    = WORD_W * w + i;
            v    = modq(coef[s / 12]);
            r[i] = v[s % 12];
        end
        return r;
    endfunction

    task automatic fill(input int kind);
        for (int k = 0; k < 256; k++) begin
            case (kind)
                0:       coef[k] = 12'd0;
                1:       coef[k] = 12'(k);
                2:       coef[k] = 12'hFFF;
                3:       coef[k] = (k == 0) ? 12'd4095 : ((k == 1) ? 12'd3329 : 12'd0);
                default: coef[k] = 12'($urandom_range(0, 4095));
            endcase
        end
    endtask

    task automatic load_poly();
        for (int k = 0; k < 256; k++) poly_i[k] = coef[k];
    endtask

    // Starts a stream from idle and consumes it under the given ready policy.
    // Returns at the negedge where done_o should be visible (or after an abort).
    task automatic run_stream(input int rmode, input int max_cyc, input int repulse_at,
                              input int abort_at, output int cycles);
        int          beat;
        int          cyc;
        bit          stalled;
        bit          r;
        logic [63:0] held;
        beat = 0; cyc = 0; stalled = 0; held = '0;
        @(negedge clk_i);
        chk1("idle_valid", valid_o, 1'b0);
        chk1("idle_done", done_o, 1'b0);
        load_poly();
        run_i = 1'b1;
        @(negedge clk_i);
        run_i = 1'b0;
        for (int k = 0; k < 256; k++) poly_i[k] = 12'($urandom_range(0, 4095));
        while (beat < N_BEATS && cyc < max_cyc) begin
            if (beat == abort_at) begin
                rst_i = 1'b1;
                #1;
                chk1("abort_valid", valid_o, 1'b0);
                chk1("abort_busy", busy_o, 1'b0);
                chk1("abort_last", last_o, 1'b0);
                @(negedge clk_i);
                rst_i = 1'b0;
                ready_i = 1'b0;
                repeat (3) begin
                    @(negedge clk_i);
                    chk1("abort_no_done", done_o, 1'b0);
                    chk1("abort_idle", valid_o, 1'b0);
                end
                cycles = cyc;
                return;
            end
            chk1("valid", valid_o, 1'b1);
            chk1("busy", busy_o, 1'b1);
            chk1("done_early", done_o, 1'b0);
            chk1("last", last_o, (beat == N_BEATS - 1));
            if (stalled) chk("stall_hold", data_o, held);
            run_i = (beat == repulse_at);
            if (run_i) for (int k = 0; k < 256; k++) poly_i[k] = ~coef[k];
            case (rmode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            ready_i = r;
            if (r) begin
                chk("beat", data_o, ref_beat(beat));
                if (beat == 0) got_b0 = data_o;
                if (beat == N_BEATS - 1) got_b47 = data_o;
                beat++;
                stalled = 0;
            end else begin
                stalled = 1;
                held = data_o;
            end
            @(negedge clk_i);
            cyc++;
        end
        run_i = 1'b0;
        ready_i = 1'b0;
        cycles = cyc;
        if (beat < N_BEATS) begin
            n_cmp++;
            n_err++;
            $display("FAIL stream_timeout: got %0d beats expected %0d", beat, N_BEATS);
        end else begin
            chk1("done_pulse", done_o, 1'b1);
            chk1("done_valid", valid_o, 1'b0);
            chk1("done_busy", busy_o, 1'b0);
            chk1("done_last", last_o, 1'b0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst_i   = 1'b1;
        run_i   = 1'b0;
        ready_i = 1'b0;
        poly_i  = '0;

        vt[0] = '{0, 0, 1'b1, 64'h0, 64'h0, 48};
        vt[1] = '{1, 0, 1'b1, 64'h5004003002001000, 64'h0FF0FE0FD0FC0FB0, 48};
        vt[2] = '{1, 1, 1'b1, 64'h5004003002001000, 64'h0FF0FE0FD0FC0FB0, 95};
        vt[3] = '{3, 0, 1'b1, T6_B0, 64'h0, 48};
        vt[4] = '{2, 0, 1'b1, FFF_B0, FFF_B47, 48};
        vt[5] = '{4, 2, 1'b0, 64'h0, 64'h0, 0};

        #1;
        chk1("rst_valid", valid_o, 1'b0);
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_done", done_o, 1'b0);
        chk1("rst_last", last_o, 1'b0);
        chk("rst_data", data_o, 64'h0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // ready_i with nothing to send must not start anything
        ready_i = 1'b1;
        @(negedge clk_i);
        chk1("idle_ready_valid", valid_o, 1'b0);
        ready_i = 1'b0;

        for (int i = 0; i < 6; i++) begin
            fill(vt[i].kind);
            run_stream(vt[i].rmode, 2000, -1, -1, cyc);
            if (vt[i].chk) begin
                chk("tbl_beat0", got_b0, vt[i].b0);
                chk("tbl_beat47", got_b47, vt[i].b47);
            end
            if (vt[i].exp_cyc > 0) chk("tbl_cycles", 64'(cyc), 64'(vt[i].exp_cyc));
        end

        // restart attempt mid-stream with a different polynomial
        fill(1);
        run_stream(0, 2000, 10, -1, cyc);

        // run_i during the DONE cycle is dropped
        run_i = 1'b1;
        load_poly();
        @(negedge clk_i);
        run_i = 1'b0;
        chk1("done_run_valid", valid_o, 1'b0);
        chk1("done_run_busy", busy_o, 1'b0);
        @(negedge clk_i);
        chk1("done_run_idle", valid_o, 1'b0);

        // reset mid-stream, then a clean restart from beat 0
        fill(4);
        run_stream(0, 2000, -1, 20, cyc);
        fill(1);
        run_stream(0, 2000, -1, -1, cyc);
        chk("restart_beat0", got_b0, 64'h5004003002001000);

        for (int i = 0; i < 4; i++) begin
            fill(4);
            run_stream(2, 2000, -1, -1, cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
